// File: rtl/xcfi_rvfi_tracer_if.sv
// xcfi_rvfi_tracer_if: pipeline-side hand-off, memory response, writeback and RVFI packet signals.
interface xcfi_rvfi_tracer_if #(parameter int XLEN = 32, parameter int ILEN = 32);
   logic            ex_valid, ex_ready, ex_mem_en, ex_mem_wen, ex_flush;
   logic [XLEN-1:0] ex_pc, ex_rs1_rdata, ex_rs2_rdata, ex_rs3_rdata, ex_mem_addr, ex_mem_wdata;
   logic [ILEN-1:0] ex_insn;
   logic [4:0]      ex_rs1_addr, ex_rs2_addr, ex_rs3_addr;
   logic [3:0]      ex_mem_strb;
   logic            mem_rsp_valid;
   logic [XLEN-1:0] mem_rsp_rdata;
   logic            wb_valid, wb_trap, wb_rd_wide;
   logic [4:0]      wb_rd_addr;
   logic [XLEN-1:0] wb_rd_wdata, wb_rd_wdatahi, wb_pc_wdata;
   logic            rvfi_valid, rvfi_trap, rvfi_intr, rvfi_halt, rvfi_rd_wide, trace_error;
   logic [63:0]     rvfi_order;
   logic [ILEN-1:0] rvfi_insn;
   logic [XLEN-1:0] rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rs3_rdata;
   logic [4:0]      rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr, rvfi_rd_addr;
   logic [XLEN-1:0] rvfi_rd_wdata, rvfi_rd_wdatahi, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
   logic [3:0]      rvfi_mem_rmask, rvfi_mem_wmask;
   modport master (
      output ex_valid, ex_ready, ex_mem_en, ex_mem_wen, ex_flush, ex_pc, ex_rs1_rdata, ex_rs2_rdata,
             ex_rs3_rdata, ex_mem_addr, ex_mem_wdata, ex_insn, ex_rs1_addr, ex_rs2_addr, ex_rs3_addr,
             ex_mem_strb, mem_rsp_valid, mem_rsp_rdata, wb_valid, wb_trap, wb_rd_wide, wb_rd_addr,
             wb_rd_wdata, wb_rd_wdatahi, wb_pc_wdata,
      input  rvfi_valid, rvfi_trap, rvfi_intr, rvfi_halt, rvfi_rd_wide, trace_error, rvfi_order,
             rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rs3_rdata,
             rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr, rvfi_rd_addr, rvfi_rd_wdata, rvfi_rd_wdatahi,
             rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata, rvfi_mem_rmask, rvfi_mem_wmask
   );
   modport slave (
      input  ex_valid, ex_ready, ex_mem_en, ex_mem_wen, ex_flush, ex_pc, ex_rs1_rdata, ex_rs2_rdata,
             ex_rs3_rdata, ex_mem_addr, ex_mem_wdata, ex_insn, ex_rs1_addr, ex_rs2_addr, ex_rs3_addr,
             ex_mem_strb, mem_rsp_valid, mem_rsp_rdata, wb_valid, wb_trap, wb_rd_wide, wb_rd_addr,
             wb_rd_wdata, wb_rd_wdatahi, wb_pc_wdata,
      output rvfi_valid, rvfi_trap, rvfi_intr, rvfi_halt, rvfi_rd_wide, trace_error, rvfi_order,
             rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rs3_rdata,
             rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr, rvfi_rd_addr, rvfi_rd_wdata, rvfi_rd_wdatahi,
             rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata, rvfi_mem_rmask, rvfi_mem_wmask
   );
endinterface

// File: rtl/xcfi_rvfi_tracer.sv
// xcfi_rvfi_tracer: 2-entry in-flight queue pairing execute state with memory and writeback,
// emitting one registered RVFI packet per retirement.
module xcfi_rvfi_tracer #(parameter int XLEN = 32, parameter int ILEN = 32) (
   input logic g_clk,
   input logic g_reset,
   xcfi_rvfi_tracer_if.slave tr
);
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] insn;
      logic [4:0]      rs1_addr, rs2_addr, rs3_addr;
      logic [XLEN-1:0] rs1_rdata, rs2_rdata, rs3_rdata, mem_addr, mem_wdata;
      logic [3:0]      rmask, wmask;
      logic            rsp_pending;
      logic [XLEN-1:0] rsp_data;
   } entry_t;
   entry_t      q [2];
   entry_t      hd, new_e;
   logic        head, tail, nxt;
   logic [1:0]  count;
   logic        intr_pend;
   logic [63:0] order_cnt;
   logic        push_req, push, pop, rsp_head, rsp_next, err;
   always_comb begin
      hd = q[head];
      nxt = head + 1'b1;
      new_e.pc = tr.ex_pc;
      new_e.insn = tr.ex_insn;
      new_e.rs1_addr = tr.ex_rs1_addr;
      new_e.rs2_addr = tr.ex_rs2_addr;
      new_e.rs3_addr = tr.ex_rs3_addr;
      new_e.rs1_rdata = tr.ex_rs1_rdata;
      new_e.rs2_rdata = tr.ex_rs2_rdata;
      new_e.rs3_rdata = tr.ex_rs3_rdata;
      new_e.mem_addr = tr.ex_mem_addr;
      new_e.mem_wdata = tr.ex_mem_wdata;
      new_e.rmask = tr.ex_mem_en && !tr.ex_mem_wen ? tr.ex_mem_strb : 4'h0;
      new_e.wmask = tr.ex_mem_en && tr.ex_mem_wen ? tr.ex_mem_strb : 4'h0;
      new_e.rsp_pending = |new_e.rmask;
      new_e.rsp_data = '0;
      push_req = tr.ex_valid && tr.ex_ready;
      pop = tr.wb_valid && count != 2'd0;
      push = push_req && !tr.ex_flush && (count != 2'd2 || pop);
      // A response always belongs to the oldest entry still waiting for one.
      rsp_head = tr.mem_rsp_valid && count != 2'd0 && hd.rsp_pending;
      rsp_next = tr.mem_rsp_valid && !rsp_head && count == 2'd2 && q[nxt].rsp_pending;
      err = (tr.mem_rsp_valid && !rsp_head && !rsp_next) || (tr.wb_valid && count == 2'd0) ||
            (push_req && !tr.ex_flush && count == 2'd2 && !pop) || (pop && hd.rsp_pending && !rsp_head);
   end
   always_ff @(posedge g_clk) begin
      tr.rvfi_halt <= 1'b0;
      if (g_reset) begin
         head <= 1'b0;
         tail <= 1'b0;
         count <= 2'd0;
         intr_pend <= 1'b0;
         order_cnt <= '0;
         tr.trace_error <= 1'b0;
         tr.rvfi_valid <= 1'b0;
         tr.rvfi_order <= '0;
         tr.rvfi_insn <= '0;
         tr.rvfi_pc_rdata <= '0;
         tr.rvfi_pc_wdata <= '0;
         tr.rvfi_trap <= 1'b0;
         tr.rvfi_intr <= 1'b0;
         tr.rvfi_rs1_addr <= '0;
         tr.rvfi_rs2_addr <= '0;
         tr.rvfi_rs3_addr <= '0;
         tr.rvfi_rs1_rdata <= '0;
         tr.rvfi_rs2_rdata <= '0;
         tr.rvfi_rs3_rdata <= '0;
         tr.rvfi_rd_addr <= '0;
         tr.rvfi_rd_wdata <= '0;
         tr.rvfi_rd_wide <= 1'b0;
         tr.rvfi_rd_wdatahi <= '0;
         tr.rvfi_mem_addr <= '0;
         tr.rvfi_mem_rmask <= '0;
         tr.rvfi_mem_wmask <= '0;
         tr.rvfi_mem_rdata <= '0;
         tr.rvfi_mem_wdata <= '0;
      end else begin
         tr.rvfi_valid <= pop;
         tr.trace_error <= tr.trace_error | err;
         if (pop) begin
            tr.rvfi_order <= order_cnt;
            order_cnt <= order_cnt + 64'd1;
            tr.rvfi_insn <= hd.insn;
            tr.rvfi_pc_rdata <= hd.pc;
            tr.rvfi_pc_wdata <= tr.wb_pc_wdata;
            tr.rvfi_trap <= tr.wb_trap;
            tr.rvfi_intr <= intr_pend;
            intr_pend <= tr.wb_trap;
            tr.rvfi_rs1_addr <= hd.rs1_addr;
            tr.rvfi_rs2_addr <= hd.rs2_addr;
            tr.rvfi_rs3_addr <= hd.rs3_addr;
            tr.rvfi_rs1_rdata <= hd.rs1_rdata;
            tr.rvfi_rs2_rdata <= hd.rs2_rdata;
            tr.rvfi_rs3_rdata <= hd.rs3_rdata;
            tr.rvfi_rd_addr <= tr.wb_trap ? 5'd0 : tr.wb_rd_addr;
            tr.rvfi_rd_wdata <= tr.wb_trap || tr.wb_rd_addr == 5'd0 ? '0 : tr.wb_rd_wdata;
            tr.rvfi_rd_wide <= !tr.wb_trap && tr.wb_rd_wide;
            tr.rvfi_rd_wdatahi <= !tr.wb_trap && tr.wb_rd_wide ? tr.wb_rd_wdatahi : '0;
            tr.rvfi_mem_addr <= hd.mem_addr;
            tr.rvfi_mem_rmask <= tr.wb_trap ? 4'h0 : hd.rmask;
            tr.rvfi_mem_wmask <= tr.wb_trap ? 4'h0 : hd.wmask;
            tr.rvfi_mem_rdata <= rsp_head ? tr.mem_rsp_rdata : hd.rsp_data;
            tr.rvfi_mem_wdata <= hd.mem_wdata;
         end
         if (rsp_head) begin
            q[head].rsp_pending <= 1'b0;
            q[head].rsp_data <= tr.mem_rsp_rdata;
         end
         if (rsp_next) begin
            q[nxt].rsp_pending <= 1'b0;
            q[nxt].rsp_data <= tr.mem_rsp_rdata;
         end
         if (push) q[tail] <= new_e;
         if (tr.ex_flush) begin
            head <= 1'b0;
            tail <= 1'b0;
            count <= 2'd0;
         end else begin
            head <= head + pop;
            tail <= tail + push;
            count <= count + 2'(push) - 2'(pop);
         end
      end
   end
endmodule

// File: tb/tb_xcfi_rvfi_tracer.sv
// tb_xcfi_rvfi_tracer: scoreboard bench; a queue model predicts each RVFI packet at wb_valid time.
module tb_xcfi_rvfi_tracer;
   logic g_clk = 1'b0, g_reset = 1'b0;
   int   n_chk = 0, n_fail = 0;
   always #5 g_clk = ~g_clk;
   xcfi_rvfi_tracer_if bus ();
   xcfi_rvfi_tracer dut (.g_clk(g_clk), .g_reset(g_reset), .tr(bus));
   typedef struct {
      logic [31:0] pc, insn, r1, r2, maddr, mwdata, rdata;
      logic [3:0]  rmask, wmask;
      logic        pend;
   } ent_t;
   typedef struct {
      logic [63:0] order;
      logic [31:0] insn, pc, pcw, r1, r2, rdw, hi, maddr, mrdata, mwdata;
      logic [4:0]  rs1a, rd;
      logic [3:0]  rmask, wmask;
      logic        trap, intr, wide;
   } pkt_t;
   ent_t        mq[$];
   pkt_t        exp_q[$];
   logic [63:0] m_order = '0;
   logic        m_intr = 1'b0, m_err = 1'b0;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic idle();
      bus.ex_valid = 0; bus.ex_ready = 1; bus.ex_mem_en = 0; bus.ex_mem_wen = 0; bus.ex_flush = 0;
      bus.ex_pc = 0; bus.ex_insn = 0; bus.ex_rs1_addr = 0; bus.ex_rs2_addr = 0; bus.ex_rs3_addr = 0;
      bus.ex_rs1_rdata = 0; bus.ex_rs2_rdata = 0; bus.ex_rs3_rdata = 0; bus.ex_mem_addr = 0;
      bus.ex_mem_strb = 0; bus.ex_mem_wdata = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_rdata = 0;
      bus.wb_valid = 0; bus.wb_trap = 0; bus.wb_rd_addr = 0; bus.wb_rd_wdata = 0; bus.wb_rd_wide = 0;
      bus.wb_rd_wdatahi = 0; bus.wb_pc_wdata = 0;
   endtask
   task automatic reset_dut();
      idle();
      g_reset = 1;
      @(posedge g_clk); #1;
      g_reset = 0;
      mq.delete(); exp_q.delete();
      m_order = 0; m_intr = 0; m_err = 0;
      check("rst_valid", bus.rvfi_valid, 0);
      check("rst_order", bus.rvfi_order, 0);
      check("rst_pc", bus.rvfi_pc_rdata, 0);
      check("rst_rd_wdata", bus.rvfi_rd_wdata, 0);
      check("rst_insn", bus.rvfi_insn, 0);
      check("rst_err", bus.trace_error, 0);
   endtask
   task automatic push(input logic [31:0] pc, insn, input logic en, wen, input logic [3:0] strb,
                       input logic [31:0] addr, wd, r1);
      ent_t e;
      bus.ex_valid = 1; bus.ex_pc = pc; bus.ex_insn = insn;
      bus.ex_rs1_addr = insn[19:15]; bus.ex_rs2_addr = insn[24:20]; bus.ex_rs3_addr = insn[31:27];
      bus.ex_rs1_rdata = r1; bus.ex_rs2_rdata = r1 ^ 32'h1234; bus.ex_rs3_rdata = r1 + 3;
      bus.ex_mem_en = en; bus.ex_mem_wen = wen; bus.ex_mem_strb = strb;
      bus.ex_mem_addr = addr; bus.ex_mem_wdata = wd;
      e.pc = pc; e.insn = insn; e.r1 = r1; e.r2 = r1 ^ 32'h1234; e.maddr = addr; e.mwdata = wd;
      e.rdata = 0;
      e.rmask = (en && !wen) ? strb : 4'h0;
      e.wmask = (en && wen) ? strb : 4'h0;
      e.pend = e.rmask != 0;
      if (mq.size() < 2) mq.push_back(e);
      else m_err = 1;
      @(posedge g_clk); #1;
      idle();
   endtask
   task automatic rsp(input logic [31:0] d);
      int   hit = -1;
      ent_t e;
      bus.mem_rsp_valid = 1; bus.mem_rsp_rdata = d;
      foreach (mq[i]) if (hit < 0 && mq[i].pend) hit = i;
      if (hit < 0) m_err = 1;
      else begin
         e = mq[hit]; e.pend = 0; e.rdata = d; mq[hit] = e;
      end
      @(posedge g_clk); #1;
      idle();
   endtask
   task automatic retire(input logic [4:0] rd, input logic [31:0] wd, pcw, input logic trap, wide,
                         input logic [31:0] hi, input logic flush);
      ent_t e;
      pkt_t p;
      bus.wb_valid = 1; bus.wb_rd_addr = rd; bus.wb_rd_wdata = wd; bus.wb_pc_wdata = pcw;
      bus.wb_trap = trap; bus.wb_rd_wide = wide; bus.wb_rd_wdatahi = hi; bus.ex_flush = flush;
      if (mq.size() == 0) m_err = 1;
      else begin
         e = mq.pop_front();
         if (e.pend) m_err = 1;
         p.order = m_order; m_order++;
         p.intr = m_intr; m_intr = trap;
         p.insn = e.insn; p.pc = e.pc; p.pcw = pcw; p.r1 = e.r1; p.r2 = e.r2; p.rs1a = e.insn[19:15];
         p.trap = trap;
         p.rd = trap ? 5'd0 : rd;
         p.rdw = (trap || rd == 0) ? 32'd0 : wd;
         p.wide = !trap && wide;
         p.hi = (!trap && wide) ? hi : 32'd0;
         p.rmask = trap ? 4'h0 : e.rmask;
         p.wmask = trap ? 4'h0 : e.wmask;
         p.maddr = e.maddr; p.mrdata = e.rdata; p.mwdata = e.mwdata;
         exp_q.push_back(p);
      end
      if (flush) mq.delete();
      @(posedge g_clk); #1;
      idle();
   endtask
   always @(negedge g_clk) begin
      pkt_t p;
      if (bus.rvfi_valid) begin
         if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
         else begin
            p = exp_q.pop_front();
            check("order", bus.rvfi_order, p.order);
            check("insn", bus.rvfi_insn, p.insn);
            check("pc_rdata", bus.rvfi_pc_rdata, p.pc);
            check("pc_wdata", bus.rvfi_pc_wdata, p.pcw);
            check("rs1_addr", bus.rvfi_rs1_addr, p.rs1a);
            check("rs1_rdata", bus.rvfi_rs1_rdata, p.r1);
            check("rs2_rdata", bus.rvfi_rs2_rdata, p.r2);
            check("trap", bus.rvfi_trap, p.trap);
            check("intr", bus.rvfi_intr, p.intr);
            check("halt", bus.rvfi_halt, 0);
            check("rd_addr", bus.rvfi_rd_addr, p.rd);
            check("rd_wdata", bus.rvfi_rd_wdata, p.rdw);
            check("rd_wide", bus.rvfi_rd_wide, p.wide);
            check("rd_wdatahi", bus.rvfi_rd_wdatahi, p.hi);
            check("mem_addr", bus.rvfi_mem_addr, p.maddr);
            check("mem_rmask", bus.rvfi_mem_rmask, p.rmask);
            check("mem_wmask", bus.rvfi_mem_wmask, p.wmask);
            check("mem_rdata", bus.rvfi_mem_rdata, p.mrdata);
            check("mem_wdata", bus.rvfi_mem_wdata, p.mwdata);
         end
      end
   end
   initial begin
      idle();
      reset_dut();
      push(32'h100, 32'h00500093, 0, 0, 4'h0, 0, 0, 0);
      retire(5'd1, 32'd5, 32'h104, 0, 0, 0, 0);
      push(32'h104, 32'h00002103, 1, 0, 4'hF, 32'h2000, 0, 32'h2000);
      rsp(32'hDEADBEEF);
      retire(5'd2, 32'hDEADBEEF, 32'h108, 0, 0, 0, 0);
      push(32'h108, 32'h00209123, 1, 1, 4'h3, 32'h3000, 32'hCAFE, 32'h3000);
      retire(5'd0, 32'd0, 32'h10C, 0, 0, 0, 0);
      check("err_clean", bus.trace_error, m_err);
      push(32'h200, 32'h00100093, 0, 0, 0, 0, 0, 1);
      push(32'h204, 32'h00200113, 0, 0, 0, 0, 0, 2);
      push(32'h208, 32'h00300193, 0, 0, 0, 0, 0, 3);
      check("err_overflow", bus.trace_error, m_err);
      retire(5'd1, 32'd1, 32'h204, 0, 0, 0, 0);
      retire(5'd2, 32'd2, 32'h208, 0, 0, 0, 0);
      reset_dut();
      push(32'h300, 32'h00000073, 0, 0, 0, 0, 0, 7);
      push(32'h400, 32'h00100093, 0, 0, 0, 0, 0, 8);
      retire(5'd5, 32'h77, 32'h400, 1, 1, 32'h9, 0);
      push(32'h404, 32'h00200113, 0, 0, 0, 0, 0, 9);
      retire(5'd1, 32'd1, 32'h404, 0, 0, 0, 0);
      retire(5'd2, 32'd2, 32'h408, 0, 0, 0, 0);
      push(32'h500, 32'h00100093, 0, 0, 0, 0, 0, 1);
      push(32'h504, 32'h00002103, 1, 0, 4'hF, 32'h40, 0, 32'h40);
      retire(5'd1, 32'd1, 32'h504, 0, 0, 0, 1);
      check("err_after_flush", bus.trace_error, m_err);
      retire(5'd3, 32'd3, 32'h600, 0, 0, 0, 0);
      check("empty_no_valid", bus.rvfi_valid, 0);
      check("err_empty_wb", bus.trace_error, m_err);
      reset_dut();
      push(32'h700, 32'h05500013, 0, 0, 0, 0, 0, 0);
      retire(5'd0, 32'h55, 32'h704, 0, 0, 0, 0);
      push(32'h704, 32'h02208033, 0, 0, 0, 0, 0, 4);
      retire(5'd3, 32'h11, 32'h708, 0, 1, 32'hAA, 0);
      push(32'h708, 32'h00100093, 0, 0, 0, 0, 0, 5);
      reset_dut();
      push(32'h800, 32'h00100093, 0, 0, 0, 0, 0, 6);
      retire(5'd1, 32'd1, 32'h804, 0, 0, 0, 0);
      push(32'h804, 32'h00002103, 1, 0, 4'h1, 32'h50, 0, 32'h50);
      retire(5'd2, 32'd0, 32'h808, 0, 0, 0, 0);
      check("err_no_rsp", bus.trace_error, m_err);
      reset_dut();
      rsp(32'h1234);
      check("err_stray_rsp", bus.trace_error, m_err);
      repeat (3) @(posedge g_clk);
      #1;
      check("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
